bist_misr_ora: RTL and testbench
================================

// Module: bist_misr_ora
// PURPOSE
//  Output response analyser for logic BIST; sits downstream of the 36-bit TPG LFSR and the CUT.
//  Compacts one CUT response word per valid cycle into a multiple-input signature register (MISR).
//  Counts accepted patterns and, after the last one, compares the signature against a golden value.
//  Drives busy/done/pass to the BIST controller.
// PARAMETERS
//  WIDTH         36        response and signature width (bits)
//  NUM_PATTERNS  1000      patterns compacted per session (>=1)
//  GOLDEN        36'h0     expected final signature
//  CNT_W         16        pattern counter width (must hold NUM_PATTERNS)
// PORTS
//  clk            in   1          rising-edge clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          begin a session (sampled in IDLE or DONE only)
//  resp_valid     in   1          resp carries a valid CUT response this cycle
//  resp           in   WIDTH      CUT response word
//  busy           out  1          high in SEED and RUN
//  done           out  1          high in DONE
//  pass           out  1          signature==GOLDEN; valid only while done=1
//  signature      out  WIDTH      current MISR contents
//  pattern_count  out  CNT_W      responses accepted this session
// BEHAVIOUR
//  Reset: state=IDLE; signature=0, pattern_count=0, busy=0, done=0, pass=0. Reset mid-session aborts it the same way.
//  FSM: IDLE -start-> SEED -> RUN -(last pattern accepted)-> DONE -start-> SEED. start ignored in SEED/RUN.
//  SEED: exactly 1 cycle; clears signature and pattern_count; resp_valid ignored.
//  RUN: on resp_valid=1 (polynomial x^36+x^25+x^12+x^5+1, matches TPG):
//   sig'[0]=sig[35]^r[0]; sig'[i]=sig[i-1]^r[i]^(i in {5,12,25} ? sig[35] : 0); pattern_count++.
//   resp_valid=0: signature and count hold (stalls of any length allowed).
//  Termination: the cycle accepting pattern NUM_PATTERNS moves to DONE; done=1 and pass registered
//   from the updated signature in the next cycle (1-cycle latency). No further compaction in DONE.
//  DONE: signature, count, pass held until start or rst. start in DONE re-enters SEED; done drops next cycle.
//  Simultaneous rst and start: rst wins. pattern_count never wraps (session ends at NUM_PATTERNS).
// CONFIGURATION
//  MISR_XMASK_EN defined: adds input resp_mask[WIDTH]; r = resp & ~resp_mask before compaction
//   (masks unknown CUT outputs). Not defined: no port, r = resp.
// TESTING (NUM_PATTERNS=4 unless stated)
//  rst mid-RUN after 2 patterns -> next cycle IDLE, signature=0, count=0, busy=0, done=0.
//  start, 4 valid resp=0, GOLDEN=0 -> signature=36'h0, count=4, done=1 and pass=1 one cycle after 4th.
//  resp=36'h1 then 3x 0 -> signature=36'h0_0000_0008; GOLDEN=36'h8 gives pass=1, GOLDEN=0 gives pass=0.
//  resp=36'h8_0000_0000 then 3x 0 -> after 2nd 36'h0_0200_1021, final 36'h0_0800_4084 (feedback taps).
//  Insert 5 resp_valid=0 cycles between patterns 2 and 3 -> same final signature as unstalled run; start pulsed in RUN ignored.
//  MISR_XMASK_EN: resp=36'h1, resp_mask=36'h1 then 3x 0 -> signature=0, pass=1 with GOLDEN=0.

Source files
------------

// File: rtl/bist_misr_ora_if.sv
// ---------------------------------------------------------------------------
// bist_misr_ora_if
//   Bundle between the logic-BIST controller / CUT side and the output
//   response analyser (bist_misr_ora).
//
//   Parameters
//     WIDTH  response / signature width in bits
//     CNT_W  pattern counter width
//
//   Signals
//     start          controller -> ORA   begin a compaction session
//     resp_valid     CUT        -> ORA   resp holds a valid response word
//     resp           CUT        -> ORA   CUT response word
//     resp_mask      CUT        -> ORA   X-mask, only with MISR_XMASK_EN defined
//     busy           ORA -> controller   session in progress (SEED/RUN)
//     done           ORA -> controller   session finished
//     pass           ORA -> controller   final signature matched golden
//     signature      ORA -> controller   current MISR contents
//     pattern_count  ORA -> controller   responses compacted this session
//
//   Modports
//     master  driver side (controller / CUT / testbench)
//     slave   analyser side (bist_misr_ora)
//
//   Optional feature macro: MISR_XMASK_EN (adds resp_mask).
// ---------------------------------------------------------------------------
interface bist_misr_ora_if #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 16
) ();

    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp;
`ifdef MISR_XMASK_EN
    logic [WIDTH-1:0] resp_mask;
`endif
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] pattern_count;

    modport master (
`ifdef MISR_XMASK_EN
        output resp_mask,
`endif
        output start,
        output resp_valid,
        output resp,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  pattern_count
    );

    modport slave (
`ifdef MISR_XMASK_EN
        input  resp_mask,
`endif
        input  start,
        input  resp_valid,
        input  resp,
        output busy,
        output done,
        output pass,
        output signature,
        output pattern_count
    );

endinterface

// File: rtl/bist_misr_ora.sv
// ---------------------------------------------------------------------------
// bist_misr_ora
//   Output response analyser for logic BIST. Each valid CUT response word is
//   compacted into a multiple-input signature register built on the same
//   primitive polynomial as the TPG (x^36 + x^25 + x^12 + x^5 + 1). After
//   NUM_PATTERNS responses the final signature is compared with GOLDEN and
//   the verdict is presented to the BIST controller.
//
//   Parameters
//     WIDTH         response and signature width (polynomial taps assume 36)
//     NUM_PATTERNS  responses compacted per session (>= 1)
//     GOLDEN        expected final signature
//     CNT_W         pattern counter width, must be able to hold NUM_PATTERNS
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset, aborts any session
//     bus   bist_misr_ora_if.slave:
//             start, resp_valid, resp (+ resp_mask) in;
//             busy, done, pass, signature, pattern_count out
//
//   Sequencing
//     IDLE -start-> SEED -> RUN -(last pattern accepted)-> DONE -start-> SEED
//     start is ignored while busy. SEED lasts one cycle and ignores
//     resp_valid. All outputs come straight from flops.
//
//   Optional feature macro: MISR_XMASK_EN
//     When defined, bits set in resp_mask are forced to zero before
//     compaction so unknown CUT outputs cannot corrupt the signature.
// ---------------------------------------------------------------------------
module bist_misr_ora #(
    parameter int               WIDTH        = 36,
    parameter int               NUM_PATTERNS = 1000,
    parameter logic [WIDTH-1:0] GOLDEN       = 36'h0,
    parameter int               CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    bist_misr_ora_if.slave bus
);

    // Feedback tap positions of x^36 + x^25 + x^12 + x^5 + 1 (bit 0 is the
    // x^0 term, which the shift path always feeds).
    localparam int TAP_A = 5;
    localparam int TAP_B = 12;
    localparam int TAP_C = 25;

    // Counter value of the final pattern of a session.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // True for bit positions that receive the MSB feedback term.
    function automatic logic is_tap(input int pos);
        return (pos == TAP_A) || (pos == TAP_B) || (pos == TAP_C);
    endfunction

    // One MISR clock: shift up by one, fold the old MSB back into bit 0
    // and the tap positions, and XOR the response word in on every bit.
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] sig,
        input logic [WIDTH-1:0] r
    );
        logic [WIDTH-1:0] nxt;
        logic             fb;
        fb     = sig[WIDTH-1];
        nxt[0] = fb ^ r[0];
        for (int i = 1; i < WIDTH; i++) begin
            nxt[i] = sig[i-1] ^ r[i] ^ (is_tap(i) ? fb : 1'b0);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] sig_r;
    logic [WIDTH-1:0] sig_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             pass_next_s;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] resp_eff_s;

    // ------------------------------------------------------------------
    // Response conditioning
    // ------------------------------------------------------------------
`ifdef MISR_XMASK_EN
    assign resp_eff_s = bus.resp & ~bus.resp_mask;
`else
    assign resp_eff_s = bus.resp;
`endif

    // The counter still holds the index of the pattern being accepted, so
    // LAST_IDX identifies the final one and the counter can never wrap.
    assign last_s = (cnt_r == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; accept_s marks a response that gets compacted.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_SEED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEED: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (bus.resp_valid) begin
                    accept_s = 1'b1;
                    if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_SEED;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Signature/counter next values. Clearing happens both on the edge
    // that enters SEED and during SEED itself, so SEED already shows a
    // clean signature and any resp_valid during SEED is discarded.
    always_comb begin
        sig_next_s = sig_r;
        cnt_next_s = cnt_r;
        if ((state_next_s == ST_SEED) || (state_r == ST_SEED)) begin
            sig_next_s = {WIDTH{1'b0}};
            cnt_next_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
            sig_next_s = misr_step(sig_r, resp_eff_s);
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            sig_next_s = sig_r;
            cnt_next_s = cnt_r;
        end
    end

    // Verdict: evaluated from the post-compaction signature on the edge
    // that accepts the last pattern, held through DONE, cleared otherwise.
    always_comb begin
        pass_next_s = 1'b0;
        if (accept_s && last_s) begin
            pass_next_s = (sig_next_s == GOLDEN);
        end else if (state_next_s == ST_DONE) begin
            pass_next_s = pass_r;
        end else begin
            pass_next_s = 1'b0;
        end
    end

    // Signature, counter and status flops; status is decoded from the
    // next state so busy/done line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            sig_r  <= sig_next_s;
            cnt_r  <= cnt_next_s;
            busy_r <= (state_next_s == ST_SEED) || (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
            pass_r <= pass_next_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.signature     = sig_r;
    assign bus.pattern_count = cnt_r;

endmodule

// File: tb/tb_bist_misr_ora.sv
// ---------------------------------------------------------------------------
// tb_bist_misr_ora
//   Self-checking bench for bist_misr_ora with NUM_PATTERNS=4. Two copies of
//   the analyser (GOLDEN=0 and GOLDEN=36'h8) receive identical stimulus so
//   both verdict polarities are covered. A reference model tracks session
//   progress and computes the signature as polynomial arithmetic over GF(2).
//   Optional feature macro: MISR_XMASK_EN (adds a masking scenario).
// ---------------------------------------------------------------------------
module tb_bist_misr_ora;

    localparam int          W    = 36;
    localparam int          NP   = 4;
    localparam logic [35:0] POLY = 36'h0_0200_1021; // x^25+x^12+x^5+1

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock.
    always #5 clk = ~clk;

    bist_misr_ora_if #(.WIDTH(W), .CNT_W(16)) if_a ();
    bist_misr_ora_if #(.WIDTH(W), .CNT_W(16)) if_b ();

    bist_misr_ora #(.WIDTH(W), .NUM_PATTERNS(NP), .GOLDEN(36'h0), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    bist_misr_ora #(.WIDTH(W), .NUM_PATTERNS(NP), .GOLDEN(36'h8), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state
    logic [35:0] m_sig   = 36'h0;
    int          m_cnt   = 0;
    bit          m_busy  = 1'b0;
    bit          m_seed  = 1'b0;
    bit          m_done  = 1'b0;
    logic [35:0] cur_mask = 36'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiply by x modulo the polynomial, then add the response word.
    function automatic logic [35:0] misr_ref(input logic [35:0] sig, input logic [35:0] r);
        logic [36:0] t;
        t = {sig, 1'b0};
        if (t[36]) t[35:0] = t[35:0] ^ POLY;
        return t[35:0] ^ r;
    endfunction

    function automatic logic [35:0] rand36();
        return {4'($urandom()), 32'($urandom())};
    endfunction

    task automatic model_update(input bit rs, input bit st, input bit vl, input logic [35:0] rp);
        if (rs) begin
            m_sig = 36'h0; m_cnt = 0; m_busy = 1'b0; m_seed = 1'b0; m_done = 1'b0;
        end else if (m_seed) begin
            m_seed = 1'b0; m_sig = 36'h0; m_cnt = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1'b1; m_seed = 1'b1; m_done = 1'b0; m_sig = 36'h0; m_cnt = 0;
            end
        end else if (vl) begin
            m_sig = misr_ref(m_sig, rp & ~cur_mask);
            m_cnt++;
            if (m_cnt == NP) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("a_busy", 64'(if_a.busy), 64'(m_busy));
        check("a_done", 64'(if_a.done), 64'(m_done));
        check("a_sig",  64'(if_a.signature), 64'(m_sig));
        check("a_cnt",  64'(if_a.pattern_count), 64'(m_cnt));
        check("b_sig",  64'(if_b.signature), 64'(m_sig));
        check("b_done", 64'(if_b.done), 64'(m_done));
        if (m_done) begin
            check("a_pass", 64'(if_a.pass), 64'(m_sig == 36'h0));
            check("b_pass", 64'(if_b.pass), 64'(m_sig == 36'h8));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // then compare outputs 1 time unit after the edge.
    task automatic tick(input bit rs, input bit st, input bit vl, input logic [35:0] rp);
        rst = rs;
        if_a.start = st; if_a.resp_valid = vl; if_a.resp = rp;
        if_b.start = st; if_b.resp_valid = vl; if_b.resp = rp;
`ifdef MISR_XMASK_EN
        if_a.resp_mask = cur_mask;
        if_b.resp_mask = cur_mask;
`endif
        @(posedge clk);
        model_update(rs, st, vl, rp);
        #1;
        check_outputs();
    endtask

    // Start a session and pass through SEED (resp_valid there must be ignored).
    task automatic open_session();
        tick(1'b0, 1'b1, 1'b0, 36'h0);
        tick(1'b0, 1'b0, 1'b1, rand36());
    endtask

    logic [35:0] vals [4];
    logic [35:0] exp_sig;

    initial begin
        if_a.start = 1'b0; if_a.resp_valid = 1'b0; if_a.resp = 36'h0;
        if_b.start = 1'b0; if_b.resp_valid = 1'b0; if_b.resp = 36'h0;
`ifdef MISR_XMASK_EN
        if_a.resp_mask = 36'h0;
        if_b.resp_mask = 36'h0;
`endif
        // Reset state
        tick(1'b1, 1'b0, 1'b0, 36'h0);
        tick(1'b1, 1'b1, 1'b1, rand36());
        check("reset_sig",  64'(if_a.signature), 64'h0);
        check("reset_busy", 64'(if_a.busy), 64'h0);
        check("reset_pass", 64'(if_a.pass), 64'h0);

        // All-zero responses
        open_session();
        for (int i = 0; i < NP; i++) tick(1'b0, 1'b0, 1'b1, 36'h0);
        check("zero_sig",     64'(if_a.signature), 64'h0);
        check("zero_cnt",     64'(if_a.pattern_count), 64'd4);
        check("zero_done",    64'(if_a.done), 64'h1);
        check("zero_pass_g0", 64'(if_a.pass), 64'h1);
        check("zero_pass_g8", 64'(if_b.pass), 64'h0);

        // Single LSB then zeros: pure shift
        open_session();
        tick(1'b0, 1'b0, 1'b1, 36'h1);
        for (int i = 0; i < NP - 1; i++) tick(1'b0, 1'b0, 1'b1, 36'h0);
        check("lsb_sig",     64'(if_a.signature), 64'h8);
        check("lsb_pass_g0", 64'(if_a.pass), 64'h0);
        check("lsb_pass_g8", 64'(if_b.pass), 64'h1);

        // DONE holds against further valid responses
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, rand36());
        check("done_hold_sig", 64'(if_a.signature), 64'h8);

        // MSB set: exercises feedback taps
        open_session();
        tick(1'b0, 1'b0, 1'b1, 36'h8_0000_0000);
        tick(1'b0, 1'b0, 1'b1, 36'h0);
        check("tap_sig2", 64'(if_a.signature), 64'h0_0200_1021);
        tick(1'b0, 1'b0, 1'b1, 36'h0);
        tick(1'b0, 1'b0, 1'b1, 36'h0);
        check("tap_sig4", 64'(if_a.signature), 64'h0_0800_4084);

        // Stall of 5 cycles between patterns 2 and 3, with start pulsed in RUN
        for (int i = 0; i < 4; i++) vals[i] = rand36();
        exp_sig = 36'h0;
        for (int i = 0; i < 4; i++) exp_sig = misr_ref(exp_sig, vals[i]);
        open_session();
        tick(1'b0, 1'b0, 1'b1, vals[0]);
        tick(1'b0, 1'b0, 1'b1, vals[1]);
        for (int i = 0; i < 5; i++) tick(1'b0, (i == 2), 1'b0, rand36());
        check("stall_busy", 64'(if_a.busy), 64'h1);
        tick(1'b0, 1'b0, 1'b1, vals[2]);
        tick(1'b0, 1'b0, 1'b1, vals[3]);
        check("stall_sig",  64'(if_a.signature), 64'(exp_sig));
        check("stall_done", 64'(if_a.done), 64'h1);

        // Reset mid-RUN after 2 patterns, with start asserted (reset wins)
        open_session();
        tick(1'b0, 1'b0, 1'b1, rand36());
        tick(1'b0, 1'b0, 1'b1, rand36());
        tick(1'b1, 1'b1, 1'b1, rand36());
        check("abort_sig",  64'(if_a.signature), 64'h0);
        check("abort_cnt",  64'(if_a.pattern_count), 64'h0);
        check("abort_busy", 64'(if_a.busy), 64'h0);
        check("abort_done", 64'(if_a.done), 64'h0);
        tick(1'b0, 1'b0, 1'b1, rand36());
        check("abort_idle", 64'(if_a.busy), 64'h0);

`ifdef MISR_XMASK_EN
        // Masked LSB contributes nothing
        open_session();
        cur_mask = 36'h1;
        tick(1'b0, 1'b0, 1'b1, 36'h1);
        cur_mask = 36'h0;
        for (int i = 0; i < NP - 1; i++) tick(1'b0, 1'b0, 1'b1, 36'h0);
        check("mask_sig",  64'(if_a.signature), 64'h0);
        check("mask_pass", 64'(if_a.pass), 64'h1);
`endif

        // Randomized traffic, including stray starts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7), rand36());
        end

        // Bounded session: must reach done within the cycle budget
        tick(1'b1, 1'b0, 1'b0, 36'h0);
        open_session();
        for (int i = 0; i < 100 && !m_done; i++) begin
            tick(1'b0, 1'b0, ($urandom_range(0, 1) == 1), rand36());
        end
        check("session_end", 64'(if_a.done), 64'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
